// File: rtl/ring_buf_arb_pkg.sv
// Shared types and width helpers for the ring_buf write-side arbiter.
// The optional starvation promotion is enabled with RING_BUF_ARB_STARVE_EN.
package ring_buf_arb_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2
  } arb_state_t;

  typedef enum logic {
    Low  = 1'b0,
    High = 1'b1
  } act_e;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index into n items.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnt_bits.sv
// Population count of a bit vector; ACT selects which level is counted.
module cnt_bits
  import ring_buf_arb_pkg::*;
#(
  parameter int   W   = 4,
  parameter act_e ACT = High
) (
  input  logic [W-1:0]        bits,
  output logic [cnt_w(W)-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      if (bits[i] == ACT) cnt = cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ring_buf_wr_arb_rr_compact.sv
// Rotating-priority request scan that packs grants into contiguous low lanes.
// Requesters flagged in prio are taken first (lowest index first), then round-robin.
module rr_compact
  import ring_buf_arb_pkg::*;
#(
  parameter int REQ   = 4,
  parameter int WRITE = 4
) (
  input  logic [REQ-1:0]                   valid,
  input  logic [REQ-1:0]                   prio,
  input  logic [idx_w(REQ)-1:0]            rr_ptr,
  input  logic [cnt_w(WRITE)-1:0]          nb,
  output logic [REQ-1:0]                   grant,
  output logic [WRITE-1:0]                 lane_vld,
  output logic [WRITE-1:0][idx_w(REQ)-1:0] lane_idx,
  output logic                             rr_any,
  output logic [idx_w(REQ)-1:0]            rr_last
);

  localparam int IW = idx_w(REQ);

  always_comb begin
    int cnt;
    int idx;
    grant    = '0;
    lane_vld = '0;
    lane_idx = '0;
    rr_any   = 1'b0;
    rr_last  = '0;
    cnt      = 0;
    idx      = 0;
    for (int i = 0; i < REQ; i++) begin
      if (prio[i] && valid[i] && (cnt < int'(nb))) begin
        grant[i] = 1'b1;
        for (int l = 0; l < WRITE; l++) begin
          if (l == cnt) begin
            lane_vld[l] = 1'b1;
            lane_idx[l] = IW'(i);
          end
        end
        cnt = cnt + 1;
      end
    end
    // Round-robin fill starting at rr_ptr, skipping anything already granted.
    for (int k = 0; k < REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQ) idx = idx - REQ;
      for (int j = 0; j < REQ; j++) begin
        if ((j == idx) && valid[j] && !grant[j] && (cnt < int'(nb))) begin
          grant[j] = 1'b1;
          for (int l = 0; l < WRITE; l++) begin
            if (l == cnt) begin
              lane_vld[l] = 1'b1;
              lane_idx[l] = IW'(j);
            end
          end
          rr_any  = 1'b1;
          rr_last = IW'(j);
          cnt     = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/ring_buf_wr_arb.sv
// Write-side arbiter and flush sequencer for one ring_buf instance.
// Define RING_BUF_ARB_STARVE_EN to add per-requester starvation promotion.
module ring_buf_wr_arb
  import ring_buf_arb_pkg::*;
#(
  parameter int REQ   = 4,
  parameter int DATA  = 64,
  parameter int DEPTH = 16,
  parameter int WRITE = 4,
  parameter int READ  = 4
`ifdef RING_BUF_ARB_STARVE_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [REQ-1:0]                req_valid,
  input  logic [REQ-1:0][DATA-1:0]      req_data,
  output logic [REQ-1:0]                req_ready,
  input  logic                          flush_req,
  input  logic [READ-1:0]               rd_en,
  output logic [WRITE-1:0]              we,
  output logic [WRITE-1:0][DATA-1:0]    wd,
  output logic                          flush_,
  output logic [$clog2(DEPTH+1)-1:0]    occ,
  output logic                          flushing
);

  localparam int OCC_W = cnt_w(DEPTH);
  localparam int LW    = cnt_w(WRITE);
  localparam int RW    = cnt_w(READ);
  localparam int IW    = idx_w(REQ);

  arb_state_t               state;
  logic                     flush_q;
  logic [OCC_W-1:0]         occ_q;
  logic [OCC_W-1:0]         occ_next;
  logic [IW-1:0]            rr_ptr;
  logic [IW-1:0]            rr_next;
  logic [LW-1:0]            nb;
  logic [REQ-1:0]           prio;
  logic [REQ-1:0]           grant;
  logic [WRITE-1:0]         lane_vld;
  logic [WRITE-1:0][IW-1:0] lane_idx;
  logic                     rr_any;
  logic [IW-1:0]            rr_last;
  logic [LW-1:0]            we_cnt;
  logic [RW-1:0]            rd_cnt;
  logic                     grant_ok;

  // Grants only in RUN; a simultaneous flush request wins over writers.
  assign grant_ok = !reset && (state == RUN) && !flush_req;

  always_comb begin
    int free_i;
    free_i = DEPTH - int'(occ_q);
    nb     = '0;
    if (grant_ok) nb = LW'((free_i < WRITE) ? free_i : WRITE);
  end

  rr_compact #(.REQ(REQ), .WRITE(WRITE)) u_rr_compact (
    .valid    (req_valid),
    .prio     (prio),
    .rr_ptr   (rr_ptr),
    .nb       (nb),
    .grant    (grant),
    .lane_vld (lane_vld),
    .lane_idx (lane_idx),
    .rr_any   (rr_any),
    .rr_last  (rr_last)
  );

  assign req_ready = grant;

  always_comb begin
    we = lane_vld;
    wd = '0;
    for (int l = 0; l < WRITE; l++) begin
      if (lane_vld[l]) wd[l] = req_data[lane_idx[l]];
    end
  end

  cnt_bits #(.W(WRITE), .ACT(High)) u_we_cnt (.bits(we),    .cnt(we_cnt));
  cnt_bits #(.W(READ),  .ACT(High)) u_rd_cnt (.bits(rd_en), .cnt(rd_cnt));

  // Over-reading is a consumer error; clamp at empty rather than wrap.
  always_comb begin
    int sum;
    sum      = int'(occ_q) + int'(we_cnt) - int'(rd_cnt);
    occ_next = (sum < 0) ? '0 : OCC_W'(sum);
  end

  assign rr_next = (int'(rr_last) == REQ - 1) ? '0 : rr_last + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      flush_q <= 1'b0;
      occ_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (flush_req) begin
            state   <= FLUSH;
            flush_q <= 1'b1;
          end
        end
        FLUSH: begin
          state   <= SETTLE;
          flush_q <= 1'b0;
        end
        SETTLE: begin
          if (!flush_req) state <= RUN;
        end
        default: begin
          state   <= RUN;
          flush_q <= 1'b0;
        end
      endcase
      if (state == FLUSH) begin
        occ_q  <= '0;
        rr_ptr <= '0;
      end else begin
        occ_q <= occ_next;
        if (rr_any) rr_ptr <= rr_next;
      end
    end
  end

  assign flushing = flush_q && !reset;
  assign flush_   = !(flush_q && !reset);
  assign occ      = occ_q;

`ifdef RING_BUF_ARB_STARVE_EN
  localparam int SW = cnt_w(STARVE_LIMIT);

  logic [REQ-1:0][SW-1:0] wait_cnt;

  always_comb begin
    prio = '0;
    for (int i = 0; i < REQ; i++) prio[i] = (int'(wait_cnt[i]) >= STARVE_LIMIT);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ; i++) begin
      if (reset || (state == FLUSH) || !req_valid[i] || grant[i]) begin
        wait_cnt[i] <= '0;
      end else if (int'(wait_cnt[i]) < STARVE_LIMIT) begin
        wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end
`else
  assign prio = '0;
`endif

endmodule

// File: doc/ring_buf_wr_arb.md
# ring_buf_wr_arb

Write-side arbiter and sequencer for one `ring_buf` instance. It shares the ring buffer's WRITE write ports among REQ independent requesters using rotating round-robin priority. Grants are packed into contiguous low-order write lanes, and the block keeps its own occupancy count so it never over-commits entries. It also sequences buffer flushes.

## Interface
- `REQ`, 4: number of requesters.
- `DATA`, 64: payload width; matches ring_buf DATA.
- `DEPTH`, 16: ring_buf depth.
- `WRITE`, 4: ring_buf write lanes.
- `READ`, 4: ring_buf read lanes.
- `STARVE_LIMIT`, 8: wait cycles before a requester is promoted (only with `RING_BUF_ARB_STARVE_EN`).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  REQ  requester i has a word.
- `req_data`  in  REQ×DATA  requester payloads.
- `req_ready`  out  REQ  word i is accepted this cycle.
- `flush_req`  in  1  request a buffer clear, level-sampled.
- `rd_en`  in  READ  mirror of the ring_buf `re` bus, active-high.
- `we`  out  WRITE  to ring_buf `we`, active-high, contiguous from bit 0.
- `wd`  out  WRITE×DATA  to ring_buf `wd`.
- `flush_`  out  1  to ring_buf `flush_`, active-low.
- `occ`  out  $clog2(DEPTH+1)  entries currently committed.
- `flushing`  out  1  high while in the FLUSH state.

## Operation
- State machine (3 states):
  - RUN: normal arbitration. `flush_req`=1 → FLUSH.
  - FLUSH: `flush_`=0, no grants, `flushing`=1; next state is always SETTLE.
  - SETTLE: no grants. `flush_req`=0 → RUN; `flush_req`=1 → stays in SETTLE, so a held `flush_req` does not re-flush.
- Free entries: `free = DEPTH - occ`. Grant budget: `nb = min(WRITE, free)`.
- Arbitration order:
  - Scan requesters starting at `rr_ptr`, wrapping modulo REQ.
  - The first `nb` requesters with `req_valid` set are granted.
  - The k-th grant drives `we[k]`=1 and `wd[k]=req_data[i]`, and sets `req_ready[i]`=1.
  - Unused lanes: `we`=0 and `wd`=0.
- `rr_ptr` update: becomes (last granted index + 1) mod REQ. It is unchanged when there are no grants.
- Occupancy update: `occ_next = occ + popcount(we) - popcount(rd_en)`.
  - Reads are credited only on the next cycle. Same-cycle reads do not enlarge `nb`.
  - An `rd_en` popcount larger than `occ` is a consumer error. `occ` saturates at 0 in that case.
- In FLUSH: `occ`←0 and `rr_ptr`←0 at the clock edge, and the `rd_en` of that cycle is ignored.
- Full (`occ`=DEPTH): `nb`=0, all `req_ready`=0.
- Empty: `nb=min(WRITE,DEPTH)`.
- Simultaneous `flush_req` and valid requests in RUN: flush wins. No grants are made that cycle.

## Timing
- `req_ready`, `we` and `wd` are combinational from `req_valid`, `req_data`, the state, `occ` and `rr_ptr`. There is zero latency from valid to accept.
- All state (FSM, `occ`, `rr_ptr`, starvation counters) updates on the rising edge of `clk`.
- While `reset`=1, the outputs are forced regardless of inputs: `req_ready`=0, `we`=0, `wd`=0, `flush_`=1, `flushing`=0.
- After the reset edge: state=RUN, `occ`=0, `rr_ptr`=0, starvation counters=0.
- Reset mid-flush returns to RUN. The ring_buf receives its own reset on the same net.
- Flush latency: `flush_req` high at edge n → `flush_` low during cycle n+1 → the earliest new grant is in the cycle after `flush_req` is seen low in SETTLE.

## Configuration
- Macro: `RING_BUF_ARB_STARVE_EN`.
- Defined:
  - Each requester has a wait counter of $clog2(STARVE_LIMIT+1) bits, saturating.
  - The counter increments when `req_valid`=1 and `req_ready`=0, and clears on grant, when `req_valid`=0, or in FLUSH.
  - Requesters at the limit are granted first, lowest index first, within `nb`.
  - The remaining budget is filled in round-robin order, skipping requesters already granted.
  - `rr_ptr` updates from the last round-robin grant only.
- Undefined: pure round-robin. The counters and the `STARVE_LIMIT` logic are absent.

## Structure
- Package `ring_buf_arb_pkg`:
  - `arb_state_t` enum (RUN, FLUSH, SETTLE).
  - Width helper constants for `occ` and the lane counters.
- Sub-module `rr_compact`: rotating priority scan plus lane compaction, producing the grant vector and lane→requester index map.
- Popcounts reuse the existing `cnt_bits` with ACT=`High`.

## Test plan
- Reset, then all 4 requesters valid, DEPTH=16, WRITE=4 → `we`=4'b1111, `req_ready`=4'b1111, `occ`=4 next cycle, `rr_ptr`=0.
- REQ=6, all valid, WRITE=4 → cycle 1 grants 0–3, cycle 2 grants 4,5,0,1, `rr_ptr`=2.
- Fill to `occ`=14 with no reads, all valid → only 2 grants (`we`=4'b0011). Next cycle at `occ`=16: `req_ready`=0. Then `rd_en`=4'b0001 → one grant becomes possible in the following cycle.
- `flush_req` pulsed while `occ`=9 and requesters valid → no grants, `flush_`=0 for exactly one cycle, `occ`=0 after, `flush_req` held 3 cycles → SETTLE holds with no second `flush_` pulse.
- With `RING_BUF_ARB_STARVE_EN`, STARVE_LIMIT=2, WRITE=1, requesters 0 and 3 always valid, `rr_ptr` forced toward 0 by traffic → requester 3 is granted no later than 3 cycles after first asserting.
- Assert `reset` mid-operation with `occ`=7 → during reset all `req_ready`=0 and `we`=0; after reset `occ`=0, state RUN.
